// File: rtl/counter_scan_ctrl.sv
// 16-bit up/down hex counter advanced by a programmable tick divider, with a
// four-digit multiplexed 7-segment scan (nibble, blank and active-low anodes).
module counter_scan_ctrl #(
    parameter int unsigned TICK_DIV = 100000000,
    parameter int unsigned SCAN_DIV = 100000,
    parameter int unsigned BLANK_LZ = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        en,
    input  logic        up,
    input  logic        load,
    input  logic [15:0] load_val,
    output logic [15:0] count,
    output logic        Rc,
    output logic [3:0]  hex,
    output logic        LE,
    output logic [3:0]  AN
);

    localparam int unsigned TW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int unsigned SW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam logic [TW-1:0] TMAX = TW'(TICK_DIV - 1);
    localparam logic [SW-1:0] SMAX = SW'(SCAN_DIV - 1);

    localparam logic [1:0] D0 = 2'd0;
    localparam logic [1:0] D1 = 2'd1;
    localparam logic [1:0] D2 = 2'd2;
    localparam logic [1:0] D3 = 2'd3;

    logic [TW-1:0] tdiv_q, tdiv_d;
    logic [SW-1:0] sdiv_q, sdiv_d;
    logic [1:0]    idx_q, idx_d;
    logic [15:0]   count_q, count_d;
    logic          rc_q, rc_d;
    logic          tick;
    logic          scan_adv;

    assign tick     = en && (tdiv_q == TMAX);
    assign scan_adv = (sdiv_q == SMAX);

    always_comb begin
        tdiv_d  = tdiv_q;
        count_d = count_q;
        rc_d    = 1'b0;
        if (load) begin
            // Load beats a coincident tick; the divider restarts its phase.
            count_d = load_val;
            tdiv_d  = '0;
        end else if (tick) begin
            tdiv_d = '0;
            if (up) begin
                count_d = count_q + 16'd1;
                rc_d    = (count_q == 16'hFFFF);
            end else begin
                count_d = count_q - 16'd1;
                rc_d    = (count_q == 16'h0000);
            end
        end else if (en) begin
            tdiv_d = tdiv_q + TW'(1);
        end
    end

    always_comb begin
        sdiv_d = scan_adv ? '0 : sdiv_q + SW'(1);
        idx_d  = scan_adv ? idx_q + 2'd1 : idx_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            tdiv_q  <= '0;
            sdiv_q  <= '0;
            idx_q   <= D0;
            count_q <= 16'h0000;
            rc_q    <= 1'b0;
        end else begin
            tdiv_q  <= tdiv_d;
            sdiv_q  <= sdiv_d;
            idx_q   <= idx_d;
            count_q <= count_d;
            rc_q    <= rc_d;
        end
    end

    assign count = count_q;
    assign Rc    = rc_q;
    assign AN    = ~(4'b0001 << idx_q);

    always_comb begin
        hex = 4'h0;
        LE  = 1'b0;
        unique case (idx_q)
            D0: hex = count_q[3:0];
            D1: begin
                hex = count_q[7:4];
                LE  = (count_q[15:4] == 12'h000);
            end
            D2: begin
                hex = count_q[11:8];
                LE  = (count_q[15:8] == 8'h00);
            end
            D3: begin
                hex = count_q[15:12];
                LE  = (count_q[15:12] == 4'h0);
            end
            default: ;
        endcase
        // D0 is never blanked, so a zero count still shows a single "0".
        if (BLANK_LZ == 0) LE = 1'b0;
    end

endmodule

// File: tb/tb_counter_scan_ctrl.sv
// Directed bench for counter_scan_ctrl (TICK_DIV=4, SCAN_DIV=2); a second
// instance with BLANK_LZ=0 shares the stimulus to check the no-blank mode.
module tb_counter_scan_ctrl;

    logic        clk = 1'b0;
    logic        rst, en, up, load;
    logic [15:0] load_val;
    logic [15:0] count, count_nb;
    logic        rc, rc_nb;
    logic [3:0]  hex, hex_nb;
    logic        le, le_nb;
    logic [3:0]  an, an_nb;

    int n_total = 0;
    int n_pass  = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    counter_scan_ctrl #(.TICK_DIV(4), .SCAN_DIV(2), .BLANK_LZ(1)) dut (
        .clk(clk), .rst(rst), .en(en), .up(up), .load(load), .load_val(load_val),
        .count(count), .Rc(rc), .hex(hex), .LE(le), .AN(an)
    );

    counter_scan_ctrl #(.TICK_DIV(4), .SCAN_DIV(2), .BLANK_LZ(0)) dut_nb (
        .clk(clk), .rst(rst), .en(en), .up(up), .load(load), .load_val(load_val),
        .count(count_nb), .Rc(rc_nb), .hex(hex_nb), .LE(le_nb), .AN(an_nb)
    );

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Align to the start of D0 (sdiv=0): pass through D3, then wait for D0.
    task automatic sync_d0(input string tag);
        int k = 0;
        while (an !== 4'b0111 && k < 20) begin cyc(1); k++; end
        check({tag, "_d3"}, {12'h0, an}, 16'h0007);
        k = 0;
        while (an !== 4'b1110 && k < 20) begin cyc(1); k++; end
        check({tag, "_d0"}, {12'h0, an}, 16'h000E);
    endtask

    initial begin
        rst = 1'b1; en = 1'b0; up = 1'b1; load = 1'b0; load_val = 16'h0000;
        cyc(3);
        rst = 1'b0;
        check("rst_count", count, 16'h0000);
        check("rst_an", {12'h0, an}, 16'h000E);
        check("rst_hex", {12'h0, hex}, 16'h0000);
        check("rst_le", {15'h0, le}, 16'h0000);
        check("rst_rc", {15'h0, rc}, 16'h0000);

        // Each digit held two cycles.
        cyc(1); check("scan_d0b", {12'h0, an}, 16'h000E);
        cyc(1); check("scan_d1a", {12'h0, an}, 16'h000D);
        check("scan_d1_blank", {15'h0, le}, 16'h0001);
        cyc(1); check("scan_d1b", {12'h0, an}, 16'h000D);
        cyc(1); check("scan_d2", {12'h0, an}, 16'h000B);
        cyc(2); check("scan_d3", {12'h0, an}, 16'h0007);
        cyc(2); check("scan_wrap", {12'h0, an}, 16'h000E);

        // Up count, one step every 4 clocks.
        en = 1'b1; up = 1'b1;
        cyc(3); check("up_pre", count, 16'h0000);
        cyc(1); check("up_1", count, 16'h0001);
        check("up_1_rc", {15'h0, rc}, 16'h0000);
        cyc(4); check("up_2", count, 16'h0002);
        cyc(4); check("up_3", count, 16'h0003);
        cyc(4); check("up_4", count, 16'h0004);

        // Freeze with tdiv=2, then resume: step after 2 more cycles.
        cyc(2);
        en = 1'b0;
        cyc(10); check("freeze", count, 16'h0004);
        en = 1'b1;
        cyc(1); check("resume_pre", count, 16'h0004);
        cyc(1); check("resume_step", count, 16'h0005);

        // Up wrap.
        load = 1'b1; load_val = 16'hFFFE;
        cyc(1); load = 1'b0;
        check("load_fffe", count, 16'hFFFE);
        cyc(4); check("wrap_ffff", count, 16'hFFFF);
        check("wrap_ffff_rc", {15'h0, rc}, 16'h0000);
        cyc(4); check("wrap_0000", count, 16'h0000);
        check("wrap_rc", {15'h0, rc}, 16'h0001);
        cyc(1); check("wrap_rc_clr", {15'h0, rc}, 16'h0000);

        // Down wrap (tdiv is now 1).
        up = 1'b0;
        cyc(2); check("dn_pre", count, 16'h0000);
        cyc(1); check("dn_ffff", count, 16'hFFFF);
        check("dn_rc", {15'h0, rc}, 16'h0001);
        cyc(1); check("dn_rc_clr", {15'h0, rc}, 16'h0000);

        // Load in the tick cycle (tdiv reaches 3 after two edges).
        up = 1'b1;
        cyc(2);
        load = 1'b1; load_val = 16'h1234;
        cyc(1); load = 1'b0;
        check("ldpri_count", count, 16'h1234);
        check("ldpri_rc", {15'h0, rc}, 16'h0000);
        cyc(3); check("ldpri_hold", count, 16'h1234);
        cyc(1); check("ldpri_next", count, 16'h1235);

        // Scan/blank with 0050.
        en = 1'b0;
        load = 1'b1; load_val = 16'h0050;
        cyc(1); load = 1'b0;
        sync_d0("sync50");
        check("b50_d0_hex", {12'h0, hex}, 16'h0000);
        check("b50_d0_le", {15'h0, le}, 16'h0000);
        cyc(2);
        check("b50_d1_hex", {12'h0, hex}, 16'h0005);
        check("b50_d1_le", {15'h0, le}, 16'h0000);
        cyc(2);
        check("b50_d2_hex", {12'h0, hex}, 16'h0000);
        check("b50_d2_le", {15'h0, le}, 16'h0001);
        check("nb_d2_le", {15'h0, le_nb}, 16'h0000);
        cyc(2);
        check("b50_d3_hex", {12'h0, hex}, 16'h0000);
        check("b50_d3_le", {15'h0, le}, 16'h0001);
        check("nb_d3_le", {15'h0, le_nb}, 16'h0000);
        check("nb_d3_hex", {12'h0, hex_nb}, 16'h0000);

        // Nibble selection with ABCD, then reset mid-D2.
        load = 1'b1; load_val = 16'hABCD;
        cyc(1); load = 1'b0;
        sync_d0("syncab");
        check("ab_d0_hex", {12'h0, hex}, 16'h000D);
        cyc(2);
        check("ab_d1_hex", {12'h0, hex}, 16'h000C);
        cyc(2);
        check("ab_d2_hex", {12'h0, hex}, 16'h000B);
        check("ab_d2_le", {15'h0, le}, 16'h0000);
        en = 1'b1;
        cyc(1); check("ab_d2_count", count, 16'hABCD);
        rst = 1'b1;
        cyc(1); rst = 1'b0;
        check("mrst_count", count, 16'h0000);
        check("mrst_an", {12'h0, an}, 16'h000E);
        check("mrst_hex", {12'h0, hex}, 16'h0000);
        check("mrst_le", {15'h0, le}, 16'h0000);
        check("mrst_rc", {15'h0, rc}, 16'h0000);
        cyc(1); check("mrst_an1", {12'h0, an}, 16'h000E);
        cyc(1); check("mrst_an2", {12'h0, an}, 16'h000D);
        check("mrst_cnt2", count, 16'h0000);
        cyc(1); check("mrst_cnt3", count, 16'h0000);
        cyc(1); check("mrst_cnt4", count, 16'h0001);
        check("mrst_an4", {12'h0, an}, 16'h000B);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/counter_scan_ctrl.md
Name: counter_scan_ctrl

Overview:
- Sequencer for the lab counter/display datapath: owns a 16-bit hex counter advanced by a programmable tick divider, and time-multiplexes its four nibbles onto the four-digit 7-segment display.
- Drives the shared hex-to-segment decoder's nibble input and LE (blank) input, plus the active-low anode lines.
- Replaces hard-wired single-digit AN and LE ties in top-level wrappers.

Parameters:
- TICK_DIV, 100000000: clk cycles per count step (1 s at 100 MHz). Legal range ≥2.
- SCAN_DIV, 100000: clk cycles each digit is lit (1 ms at 100 MHz). Legal range ≥1.
- BLANK_LZ, 1: 1 blanks leading-zero digits; 0 always shows all four.

Ports:
- clk  in  1  system clock, all logic rising-edge.
- rst  in  1  reset; synchronous and active-high.
- en  in  1  count enable, sampled each cycle.
- up  in  1  direction: 1 = +1, 0 = −1.
- load  in  1  synchronous load strobe.
- load_val  in  16  value loaded into count.
- count  out  16  current counter value (registered).
- Rc  out  1  one-cycle wrap pulse (registered).
- hex  out  4  nibble for decoder: count[4*idx+3 : 4*idx].
- LE  out  1  decoder blank, 1 = digit dark.
- AN  out  4  anodes, active-low, one-hot-zero.

Behaviour:
- Reset (rst=1 at clk edge) forces:
  - count=16'h0000, Rc=0.
  - Tick divider=0, scan divider=0, digit state=D0.
  - Resulting outputs: AN=4'b1110, hex=4'h0, LE=0.
- Reset mid-operation aborts any tick or scan phase. No pulse on Rc.
- Tick divider:
  - tdiv counts 0..TICK_DIV-1 while en=1, then wraps to 0.
  - tick is asserted in the cycle with tdiv==TICK_DIV-1 and en=1.
  - en=0 freezes tdiv; the phase is preserved.
- Count update, priority rst > load > tick:
  - load=1: count<=load_val; tdiv<=0; Rc<=0, regardless of en/tick.
  - tick, up=1: count<=count+1, mod 2^16. Rc<=1 iff count was 16'hFFFF.
  - tick, up=0: count<=count-1, mod 2^16. Rc<=1 iff count was 16'h0000.
  - Otherwise count holds and Rc<=0, so Rc is high for exactly one cycle.
- Scan FSM:
  - States D0→D1→D2→D3→D0 (idx 0..3).
  - sdiv counts 0..SCAN_DIV-1 continuously, independent of en and load.
  - On sdiv==SCAN_DIV-1 the state advances.
  - SCAN_DIV=1 advances every cycle.
- Outputs are combinational from registered state (zero latency):
  - AN = ~(4'b0001 << idx).
  - hex = nibble idx of count.
- LE:
  - BLANK_LZ=1: LE=1 iff idx>0 and count[15:4*idx]==0.
  - D0 is never blanked, so 0000 displays "0".
  - BLANK_LZ=0: LE=0 always.
- Simultaneous load and tick: load wins; that tick is lost and the divider restarts.
- The count changes whenever its update fires, including mid-digit. The display reflects the new value immediately; no display latching.

Test Plan (TICK_DIV=4, SCAN_DIV=2, BLANK_LZ=1 unless stated):
- Reset: hold rst 3 cycles then release → count=0000, AN=1110, hex=0, LE=0, Rc=0. Then AN steps 1110→1101→1011→0111→1110, each held for 2 cycles.
- Up count: en=1, up=1, count 4 ticks → count 0000→0001→0002→0003→0004, one step every 4 clk.
  - en dropped for 10 cycles → count and tdiv frozen.
  - Next step comes exactly 4−(phase) cycles after en returns.
- Wrap:
  - load FFFE, up=1 → FFFF, then 0000 with Rc=1 for one cycle.
  - up=0 from 0000 → FFFF with Rc=1 for one cycle.
- Load priority: assert load with load_val=1234 in the tick cycle → count=1234, no increment, no Rc. Next increment lands 4 cycles later.
- Scan/blank with count=0050:
  - D0: hex=0, LE=0. D1: hex=5, LE=0.
  - D2: hex=0, LE=1. D3: hex=0, LE=1.
  - With BLANK_LZ=0, LE=0 in all states.
- Mid-operation reset during a D2 phase with count=ABCD → next cycle count=0000, AN=1110, sdiv and tdiv restart from 0.
